ahb_matrix_out: RTL and testbench

- Per-slave output stage of the AHB multi-layer matrix; one instance per slave port, plus one for the default slave.
- Receives address/control/write-data buses of all MNUM masters.
- Arbitrates among masters whose (pre-decoded) htrans targets this slave and muxes the winner onto the slave bus.
- Returns slave read data/response plus a per-master hready vector that stalls losing masters.

---
 rtl/ahb_matrix_out.sv | 157 +++++++++++++++
 tb/tb_ahb_matrix_out.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_out.sv
// Per-slave output stage of the AHB multi-layer matrix: arbitrates masters onto one slave port.
// Define AHB_MATRIX_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ahb_matrix_out #(
    parameter int MNUM = 8
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [MNUM*32-1:0]  im_haddr,
    input  logic [MNUM*2-1:0]   im_htrans,
    input  logic [MNUM-1:0]     im_hwrite,
    input  logic [MNUM*3-1:0]   im_hsize,
    input  logic [MNUM*3-1:0]   im_hburst,
    input  logic [MNUM*4-1:0]   im_hprot,
    input  logic [MNUM*32-1:0]  im_hwdata,
    output logic [31:0]         om_hrdata,
    output logic [MNUM-1:0]     om_hready,
    output logic [1:0]          om_hresp,
    output logic [31:0]         os_haddr,
    output logic                os_hwrite,
    output logic [2:0]          os_hsize,
    output logic [2:0]          os_hburst,
    output logic [3:0]          os_hprot,
    output logic [1:0]          os_htrans,
    output logic [31:0]         os_hwdata,
    output logic                os_hsel,
    input  logic [31:0]         is_hrdata,
    input  logic                is_hready,
    input  logic [1:0]          is_hresp
);
    localparam int IW = (MNUM > 1) ? $clog2(MNUM) : 1;

    logic [MNUM-1:0] req;
    logic            rdy;
    logic [IW-1:0]   owner;
    logic            valid;
    logic [1:0]      lock_htrans;

    logic            data_active_q, data_active_d;
    logic [IW-1:0]   data_owner_q, data_owner_d;
    logic [IW-1:0]   addr_owner_q, addr_owner_d;
    logic            addr_valid_q, addr_valid_d;
`ifndef AHB_MATRIX_FIXED_PRIO_EN
    logic [IW-1:0]   last_grant_q, last_grant_d;
`endif

    always_comb begin
        for (int m = 0; m < MNUM; m++) begin
            req[m] = im_htrans[2*m+1];
        end
    end

    // With no data phase outstanding the slave's hready is irrelevant.
    assign rdy         = !data_active_q || is_hready;
    assign lock_htrans = im_htrans[2*int'(addr_owner_q) +: 2];

    always_comb begin
        owner = '0;
        valid = 1'b0;
        if (addr_valid_q && (!rdy || lock_htrans == 2'b11 || lock_htrans == 2'b01)) begin
            owner = addr_owner_q;
            valid = 1'b1;
        end else begin
`ifdef AHB_MATRIX_FIXED_PRIO_EN
            for (int m = 0; m < MNUM; m++) begin
                if (!valid && req[m]) begin
                    owner = IW'(m);
                    valid = 1'b1;
                end
            end
`else
            // First look above the last winner, then wrap around to index 0.
            for (int m = 0; m < MNUM; m++) begin
                if (!valid && req[m] && m > int'(last_grant_q)) begin
                    owner = IW'(m);
                    valid = 1'b1;
                end
            end
            for (int m = 0; m < MNUM; m++) begin
                if (!valid && req[m]) begin
                    owner = IW'(m);
                    valid = 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        addr_owner_d  = owner;
        addr_valid_d  = valid;
        data_active_d = data_active_q;
        data_owner_d  = data_owner_q;
        if (rdy) begin
            data_active_d = valid && req[owner];
            data_owner_d  = owner;
        end
    end

`ifndef AHB_MATRIX_FIXED_PRIO_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (rdy && valid && req[owner]) begin
            last_grant_d = owner;
        end
    end
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            data_active_q <= 1'b0;
            data_owner_q  <= '0;
            addr_owner_q  <= '0;
            addr_valid_q  <= 1'b0;
`ifndef AHB_MATRIX_FIXED_PRIO_EN
            last_grant_q  <= IW'(MNUM - 1);
`endif
        end else begin
            data_active_q <= data_active_d;
            data_owner_q  <= data_owner_d;
            addr_owner_q  <= addr_owner_d;
            addr_valid_q  <= addr_valid_d;
`ifndef AHB_MATRIX_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign om_hrdata = is_hrdata;
    assign om_hresp  = is_hresp;

    always_comb begin
        os_haddr  = im_haddr[32*int'(owner) +: 32];
        os_hwrite = im_hwrite[owner];
        os_hsize  = im_hsize[3*int'(owner) +: 3];
        os_hburst = im_hburst[3*int'(owner) +: 3];
        os_hprot  = im_hprot[4*int'(owner) +: 4];
        os_hwdata = im_hwdata[32*int'(data_owner_q) +: 32];
        os_hsel   = valid && !hreset;
        os_htrans = (valid && !hreset) ? im_htrans[2*int'(owner) +: 2] : 2'b00;
    end

    // Handshake: a master's transfer advances only on a cycle where its om_hready is 1;
    // the data-phase owner sees the slave's ready, the address owner sees rdy, losers are held at 0.
    always_comb begin
        for (int m = 0; m < MNUM; m++) begin
            if (hreset) begin
                om_hready[m] = 1'b1;
            end else if (data_active_q && data_owner_q == IW'(m)) begin
                om_hready[m] = is_hready;
            end else if (valid && owner == IW'(m)) begin
                om_hready[m] = rdy;
            end else begin
                om_hready[m] = !req[m];
            end
        end
    end
endmodule

// File: tb/tb_ahb_matrix_out.sv
// Self-checking bench for ahb_matrix_out: directed scenarios plus randomized traffic against a reference model.
module tb_ahb_matrix_out;
    localparam int MNUM = 8;

    logic                hclk;
    logic                hreset;
    logic [MNUM*32-1:0]  im_haddr;
    logic [MNUM*2-1:0]   im_htrans;
    logic [MNUM-1:0]     im_hwrite;
    logic [MNUM*3-1:0]   im_hsize;
    logic [MNUM*3-1:0]   im_hburst;
    logic [MNUM*4-1:0]   im_hprot;
    logic [MNUM*32-1:0]  im_hwdata;
    logic [31:0]         om_hrdata;
    logic [MNUM-1:0]     om_hready;
    logic [1:0]          om_hresp;
    logic [31:0]         os_haddr;
    logic                os_hwrite;
    logic [2:0]          os_hsize;
    logic [2:0]          os_hburst;
    logic [3:0]          os_hprot;
    logic [1:0]          os_htrans;
    logic [31:0]         os_hwdata;
    logic                os_hsel;
    logic [31:0]         is_hrdata;
    logic                is_hready;
    logic [1:0]          is_hresp;

    ahb_matrix_out #(.MNUM(MNUM)) dut (
        .hclk(hclk), .hreset(hreset),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
        .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot),
        .im_hwdata(im_hwdata),
        .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
        .os_haddr(os_haddr), .os_hwrite(os_hwrite), .os_hsize(os_hsize),
        .os_hburst(os_hburst), .os_hprot(os_hprot), .os_htrans(os_htrans),
        .os_hwdata(os_hwdata), .os_hsel(os_hsel),
        .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
    );

    // clock / reset block
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    // reference model state: what the port remembers between cycles
    int m_da, m_do, m_av, m_ao, m_lg;
    int e_own;
    bit e_vld, e_rdy;
    int tally [MNUM];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [31:0] wd);
        im_htrans[2*m +: 2]  = tr;
        im_haddr[32*m +: 32] = a;
        im_hwrite[m]         = w;
        im_hwdata[32*m +: 32] = wd;
        im_hsize[3*m +: 3]   = 3'($urandom_range(0, 7));
        im_hburst[3*m +: 3]  = 3'($urandom_range(0, 7));
        im_hprot[4*m +: 4]   = 4'($urandom_range(0, 15));
    endtask

    task automatic idle_all();
        im_htrans = '0;
    endtask

    // Settle, compute the expected port behaviour from the arbitration rules, compare.
    task automatic eval();
        logic [MNUM-1:0] exp_rdy;
        logic [1:0] ot;
        int bestd, d;
        #3;
        e_rdy = (m_da == 0) || is_hready;
        ot = im_htrans[2*m_ao +: 2];
        e_vld = 1'b0;
        e_own = 0;
        if (m_av != 0 && (!e_rdy || ot == 2'b11 || ot == 2'b01)) begin
            e_own = m_ao;
            e_vld = 1'b1;
        end else begin
            bestd = MNUM;
            for (int m = 0; m < MNUM; m++) begin
                if (im_htrans[2*m+1]) begin
`ifdef AHB_MATRIX_FIXED_PRIO_EN
                    d = m;
`else
                    d = (m - m_lg - 1 + 2*MNUM) % MNUM;
`endif
                    if (d < bestd) begin
                        bestd = d;
                        e_own = m;
                        e_vld = 1'b1;
                    end
                end
            end
        end
        for (int m = 0; m < MNUM; m++) begin
            if (m_da != 0 && m == m_do) exp_rdy[m] = is_hready;
            else if (e_vld && m == e_own) exp_rdy[m] = e_rdy;
            else exp_rdy[m] = !im_htrans[2*m+1];
        end
        check("hrdata", om_hrdata, is_hrdata);
        check("hresp", {30'd0, om_hresp}, {30'd0, is_hresp});
        if (hreset) begin
            check("rst_hsel", {31'd0, os_hsel}, 32'd0);
            check("rst_htrans", {30'd0, os_htrans}, 32'd0);
            check("rst_hready", om_hready, {MNUM{1'b1}});
        end else begin
            check("hsel", {31'd0, os_hsel}, {31'd0, e_vld});
            check("htrans", {30'd0, os_htrans}, e_vld ? {30'd0, im_htrans[2*e_own +: 2]} : 32'd0);
            check("hready", om_hready, exp_rdy);
            if (e_vld) begin
                check("haddr", os_haddr, im_haddr[32*e_own +: 32]);
                check("ctrl", {21'd0, os_hwrite, os_hsize, os_hburst, os_hprot},
                      {21'd0, im_hwrite[e_own], im_hsize[3*e_own +: 3],
                       im_hburst[3*e_own +: 3], im_hprot[4*e_own +: 4]});
            end
            if (m_da != 0) check("hwdata", os_hwdata, im_hwdata[32*m_do +: 32]);
        end
    endtask

    // Clock edge: advance the model with the values that were present at the edge.
    task automatic adv();
        @(posedge hclk);
        if (hreset) begin
            m_da = 0; m_do = 0; m_av = 0; m_ao = 0; m_lg = MNUM - 1;
        end else begin
            m_ao = e_own;
            m_av = int'(e_vld);
            if (e_rdy) begin
                m_da = int'(e_vld && im_htrans[2*e_own+1]);
                m_do = e_own;
            end
            if (e_rdy && e_vld && im_htrans[2*e_own+1]) m_lg = e_own;
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    initial begin
        int r;
        hreset = 1'b1;
        is_hready = 1'b1; is_hresp = 2'b00; is_hrdata = '0;
        im_haddr = '0; im_htrans = '0; im_hwrite = '0; im_hsize = '0;
        im_hburst = '0; im_hprot = '0; im_hwdata = '0;
        m_da = 0; m_do = 0; m_av = 0; m_ao = 0; m_lg = MNUM - 1;
        e_own = 0; e_vld = 1'b0; e_rdy = 1'b1;

        cyc(); cyc();
        hreset = 1'b0;

        // single master, address then data phase
        set_m(2, 2'b10, 32'h1000, 1'b1, 32'hA5A5A5A5);
        eval();
        check("s1_hsel", {31'd0, os_hsel}, 32'd1);
        check("s1_haddr", os_haddr, 32'h1000);
        check("s1_htrans", {30'd0, os_htrans}, 32'd2);
        adv();
        set_m(2, 2'b00, 32'h1000, 1'b1, 32'hA5A5A5A5);
        eval();
        check("s1_hwdata", os_hwdata, 32'hA5A5A5A5);
        check("s1_hready2", {31'd0, om_hready[2]}, 32'd1);
        adv();

        // contention between masters 0 and 1
        set_m(0, 2'b10, 32'h100, 1'b0, 32'h0);
        set_m(1, 2'b10, 32'h200, 1'b0, 32'h0);
        eval();
        check("c_grant0", os_haddr, 32'h100);
        check("c_stall1", {31'd0, om_hready[1]}, 32'd0);
        adv();
        for (int k = 1; k < 4; k++) begin
            eval();
`ifndef AHB_MATRIX_FIXED_PRIO_EN
            check("c_alternate", os_haddr, (k % 2 == 1) ? 32'h200 : 32'h100);
`endif
            adv();
        end
        idle_all(); cyc();

        // wait states during master 3's burst, master 4 held off
        set_m(3, 2'b10, 32'h300, 1'b1, 32'h33);
        eval();
        check("w_grant3", os_haddr, 32'h300);
        adv();
        set_m(3, 2'b11, 32'h304, 1'b1, 32'h33);
        set_m(4, 2'b10, 32'h400, 1'b0, 32'h0);
        is_hready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            eval();
            check("w_hold_addr", os_haddr, 32'h304);
            check("w_rdy3_low", {31'd0, om_hready[3]}, 32'd0);
            check("w_rdy4_low", {31'd0, om_hready[4]}, 32'd0);
            adv();
        end
        is_hready = 1'b1;
        eval();
        check("w_rdy3_high", {31'd0, om_hready[3]}, 32'd1);
        check("w_lock4", {31'd0, om_hready[4]}, 32'd0);
        adv();
        set_m(3, 2'b00, 32'h308, 1'b1, 32'h33);
        eval();
        check("w_grant4", os_haddr, 32'h400);
        adv();
        idle_all(); cyc();

        // INCR4 burst lock by master 1 against master 0
        set_m(1, 2'b10, 32'h500, 1'b1, 32'h0);
        eval();
        check("b_grant1", os_haddr, 32'h500);
        adv();
        set_m(0, 2'b10, 32'h600, 1'b0, 32'h0);
        for (int k = 1; k < 4; k++) begin
            set_m(1, 2'b11, 32'h500 + 4*k, 1'b1, k);
            eval();
            check("b_lock_addr", os_haddr, 32'h500 + 4*k);
            check("b_stall0", {31'd0, om_hready[0]}, 32'd0);
            adv();
        end
        set_m(1, 2'b00, 32'h510, 1'b1, 32'h4);
        eval();
        check("b_grant0", os_haddr, 32'h600);
        check("b_rdy0", {31'd0, om_hready[0]}, 32'd1);
        adv();

        // two-cycle ERROR response for master 0's data phase
        set_m(0, 2'b00, 32'h600, 1'b0, 32'h0);
        is_hresp = 2'b01; is_hready = 1'b0;
        eval();
        check("e_resp1", {30'd0, om_hresp}, 32'd1);
        check("e_rdy_low", {31'd0, om_hready[0]}, 32'd0);
        adv();
        is_hready = 1'b1;
        eval();
        check("e_resp2", {30'd0, om_hresp}, 32'd1);
        check("e_rdy_high", {31'd0, om_hready[0]}, 32'd1);
        adv();
        is_hresp = 2'b00;
        cyc();

        // reset in the middle of a stalled data phase
        set_m(5, 2'b10, 32'h700, 1'b0, 32'h0);
        eval();
        check("r_grant5", os_haddr, 32'h700);
        adv();
        set_m(5, 2'b00, 32'h700, 1'b0, 32'h0);
        is_hready = 1'b0; hreset = 1'b1;
        eval();
        check("r_forced_rdy", om_hready, {MNUM{1'b1}});
        check("r_forced_hsel", {31'd0, os_hsel}, 32'd0);
        adv();
        hreset = 1'b0;
        eval();
        check("r_after_rdy", om_hready, {MNUM{1'b1}});
        check("r_after_hsel", {31'd0, os_hsel}, 32'd0);
        adv();
        is_hready = 1'b1;

        // all masters request continuously: two full rounds give each master two grants
        for (int m = 0; m < MNUM; m++) begin
            tally[m] = 0;
            set_m(m, 2'b10, 32'h10000 + m, 1'b0, 32'h0);
        end
        for (int k = 0; k < 2*MNUM; k++) begin
            eval();
            if (os_hsel) tally[os_haddr[3:0]]++;
            adv();
        end
        idle_all(); cyc();
`ifndef AHB_MATRIX_FIXED_PRIO_EN
        for (int m = 0; m < MNUM; m++) check("fair_grants", tally[m], 32'd2);
`endif

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            for (int m = 0; m < MNUM; m++) begin
                r = $urandom_range(0, 9);
                set_m(m, (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11,
                      $urandom, 1'($urandom_range(0, 1)), $urandom);
            end
            is_hready = ($urandom_range(0, 3) != 0);
            is_hresp  = 2'($urandom_range(0, 3));
            is_hrdata = $urandom;
            hreset    = ($urandom_range(0, 99) == 0);
            cyc();
        end
        hreset = 1'b0;
        idle_all(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
